// File: rtl/aes_decrypt_ctrl.sv
// AES decryption round sequencer: steps the external round counter, selects the round key
// and datapath muxes for one block at a time, and flags illegal round-counter values.
module aes_decrypt_ctrl #(
  parameter int NR = 10
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       start,
  output logic       in_ready,
  input  logic [3:0] round_cnt,
  output logic       cnt_en,
  output logic       cnt_clr_n,
  output logic       load_state,
  output logic       sel_mix,
  output logic [3:0] key_addr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, INIT, ROUND, LAST, HOLD} state_t;

  localparam logic [3:0] NR_4     = 4'(NR);
  localparam logic [3:0] LAST_CNT = 4'(NR - 1);

  state_t state_reg;
  state_t state_next;
  logic   err_next;
  logic   round_bad;

  assign round_bad = (round_cnt == 4'd0) || (round_cnt >= NR_4);

  always_comb begin
    state_next = state_reg;
    err_next   = err;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = INIT;
          err_next   = 1'b0;
        end
      end
      INIT: state_next = ROUND;
      ROUND: begin
        if (round_cnt == LAST_CNT) begin
          state_next = LAST;
        end else if (round_bad) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end
      end
      LAST: state_next = HOLD;
      HOLD: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control outputs are registered by decoding the state being entered.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_reg  <= IDLE;
      err        <= 1'b0;
      in_ready   <= 1'b1;
      cnt_clr_n  <= 1'b0;
      cnt_en     <= 1'b0;
      load_state <= 1'b0;
      sel_mix    <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      err        <= err_next;
      in_ready   <= (state_next == IDLE);
      cnt_clr_n  <= (state_next != IDLE);
      cnt_en     <= (state_next == INIT) || (state_next == ROUND);
      load_state <= (state_next == INIT);
      sel_mix    <= (state_next == ROUND);
      out_valid  <= (state_next == HOLD);
    end
  end

  // Decryption walks the key schedule backwards: NR at load, down to 0 in the last round.
  always_comb begin
    key_addr = 4'd0;
    case (state_reg)
      INIT:    key_addr = NR_4;
      ROUND:   key_addr = NR_4 - round_cnt;
      default: key_addr = 4'd0;
    endcase
  end

endmodule
